cpu_run_ctrl: RTL and testbench

Run/halt sequencer for the single-cycle CPU core. It produces the commit enable (cpu_en) that gates PC update, regfile write and dMem write. It stalls the core while the multi-cycle ALU is busy, and it provides run, halt and single-step control, a PC breakpoint, an ALU watchdog, and cycle/instruction counters. It sits beside cpu_top: it takes pc_value and control-unit/ALU status, and drives the enables.

---
 rtl/cpu_run_ctrl.sv | 155 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt sequencer for the single-cycle CPU core.
// Generates the commit enable (cpu_en) that gates PC update, regfile write
// and dMem write. Stalls commit while the multi-cycle ALU works, and
// provides run / halt / single-step control, a PC breakpoint, an ALU
// watchdog, and cycle / retired-instruction counters.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   run_req/halt_req/step_req  one-cycle control pulses
//   bp_en, bp_addr      PC breakpoint
//   pc_value            current PC
//   multi_op            current instruction needs the multi-cycle ALU
//   alu_done, alu_error multi-cycle ALU completion / error
//   cpu_en              commit enable (combinational)
//   alu_start           one-cycle launch pulse for the multi-cycle ALU
//   state               0=HOLD 1=HALT 2=EXEC 3=ALU_WAIT
//   halted              high in HOLD and HALT
//   halt_cause          0=req/step 1=breakpoint 2=ALU error 3=watchdog
//   cycle_cnt           EXEC + ALU_WAIT cycles
//   instret_cnt         committed instructions
module cpu_run_ctrl #(
  parameter int RESET_HOLD = 4,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_value,
  input  logic             multi_op,
  input  logic             alu_done,
  input  logic             alu_error,
  output logic             cpu_en,
  output logic             alu_start,
  output logic [1:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int WW = $clog2(WDOG_LIMIT);

  logic [1:0]    state_q, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [WW-1:0] wdog_cnt;
  logic          step_mode, resume_skip, halt_pend;
  logic          halt_entry;
  logic [1:0]    cause_nxt;
  logic          bp_hit, resume;

  // resume_skip lets the instruction sitting on the breakpoint commit once
  // after a resume instead of re-trapping forever.
  assign bp_hit = bp_en && (pc_value == bp_addr) && !resume_skip;
  assign resume = (state_q == S_HALT) && (run_req || step_req);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_HOLD;
    else      state_q <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt  = state_q;
    halt_entry = 1'b0;
    cause_nxt  = 2'd0;
    case (state_q)
      S_HOLD: if (hold_cnt == HW'(RESET_HOLD - 1)) state_nxt = S_HALT;
      S_HALT: if (run_req || step_req) state_nxt = S_EXEC;
      S_EXEC: begin
        if (bp_hit) begin
          state_nxt = S_HALT; halt_entry = 1'b1; cause_nxt = 2'd1;
        end else if (multi_op) begin
          state_nxt = S_WAIT;
        end else if (step_mode || halt_req || halt_pend) begin
          state_nxt = S_HALT; halt_entry = 1'b1; cause_nxt = 2'd0;
        end
      end
      default: begin
        if (alu_done) begin
          if (alu_error) begin
            state_nxt = S_HALT; halt_entry = 1'b1; cause_nxt = 2'd2;
          end else if (step_mode || halt_req || halt_pend) begin
            state_nxt = S_HALT; halt_entry = 1'b1; cause_nxt = 2'd0;
          end else begin
            state_nxt = S_EXEC;
          end
        end else if (wdog_cnt == WW'(WDOG_LIMIT - 1)) begin
          state_nxt = S_HALT; halt_entry = 1'b1; cause_nxt = 2'd3;
        end
      end
    endcase
  end

  // outputs
  always_comb begin
    cpu_en    = 1'b0;
    alu_start = 1'b0;
    case (state_q)
      S_EXEC: begin
        cpu_en    = !bp_hit && !multi_op;
        alu_start = !bp_hit && multi_op;
      end
      S_WAIT:  cpu_en = alu_done && !alu_error;
      default: ;
    endcase
  end

  assign state  = state_q;
  assign halted = (state_q == S_HOLD) || (state_q == S_HALT);

  // counters, flags and cause
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt    <= '0;
      wdog_cnt    <= '0;
      step_mode   <= 1'b0;
      resume_skip <= 1'b0;
      halt_pend   <= 1'b0;
      halt_cause  <= 2'd0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q == S_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (alu_start)              wdog_cnt <= '0;
      else if (state_q == S_WAIT) wdog_cnt <= wdog_cnt + 1'b1;
      if (state_q == S_EXEC || state_q == S_WAIT) cycle_cnt <= cycle_cnt + 1'b1;
      if (cpu_en) begin
        instret_cnt <= instret_cnt + 1'b1;
        resume_skip <= 1'b0;
      end
      // A halt_req arriving while the instruction has not yet committed
      // (including the alu_start cycle) is held until the commit.
      if ((state_q == S_EXEC || state_q == S_WAIT) && halt_req) halt_pend <= 1'b1;
      if (resume) begin
        step_mode   <= !run_req;
        resume_skip <= 1'b1;
        halt_pend   <= 1'b0;
      end
      if (halt_entry) halt_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
  localparam int RESET_HOLD = 4;
  localparam int CNT_W      = 32;
  localparam int WDOG_LIMIT = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic run_req = 0, halt_req = 0, step_req = 0, bp_en = 0;
  logic [31:0] bp_addr = 0, pc_value = 0;
  logic multi_op = 0, alu_done = 0, alu_error = 0;
  logic cpu_en, alu_start, halted;
  logic [1:0] state, halt_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  cpu_run_ctrl #(.RESET_HOLD(RESET_HOLD), .CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_value(pc_value), .multi_op(multi_op),
    .alu_done(alu_done), .alu_error(alu_error), .cpu_en(cpu_en), .alu_start(alu_start),
    .state(state), .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // ---------------- reference model ----------------
  // mode: 0 hold, 1 halt, 2 exec, 3 alu wait
  int          m_mode, m_held, m_waited, m_cause;
  bit          m_step, m_skip, m_pend;
  logic [CNT_W-1:0] m_cyc, m_ins;
  bit          e_en, e_start, e_bp;

  task automatic model_reset();
    m_mode = 0; m_held = 0; m_waited = 0; m_cause = 0;
    m_step = 0; m_skip = 0; m_pend = 0; m_cyc = '0; m_ins = '0;
  endtask

  task automatic model_eval();
    e_bp    = bp_en && (pc_value == bp_addr) && !m_skip;
    e_en    = (m_mode == 2 && !e_bp && !multi_op) || (m_mode == 3 && alu_done && !alu_error);
    e_start = (m_mode == 2 && !e_bp && multi_op);
  endtask

  task automatic model_halt(input int cause);
    m_mode = 1; m_cause = cause;
  endtask

  task automatic model_advance();
    if (m_mode >= 2) m_cyc++;
    if (e_en) begin m_ins++; m_skip = 0; end
    if (m_mode >= 2 && halt_req) m_pend = 1;
    case (m_mode)
      0: begin m_held++; if (m_held == RESET_HOLD) m_mode = 1; end
      1: if (run_req || step_req) begin
           m_mode = 2; m_step = !run_req; m_skip = 1; m_pend = 0;
         end
      2: if (e_bp) model_halt(1);
         else if (multi_op) begin m_mode = 3; m_waited = 0; end
         else if (m_step || m_pend) model_halt(0);
      default: begin
        m_waited++;
        if (alu_done) begin
          if (alu_error) model_halt(2);
          else if (m_step || m_pend) model_halt(0);
          else m_mode = 2;
        end else if (m_waited == WDOG_LIMIT) model_halt(3);
      end
    endcase
  endtask

  // ---------------- cycle driver ----------------
  logic s_en, s_start;
  logic [1:0] s_state;
  logic [CNT_W-1:0] s_ins, s_cyc;
  logic [31:0] tb_pc = 0;

  task automatic cycle();
    logic [6:0] act, exp;
    if (!rst) model_reset();
    @(negedge clk);
    model_eval();
    s_en = cpu_en; s_start = alu_start; s_state = state; s_ins = instret_cnt; s_cyc = cycle_cnt;
    act = {state, cpu_en, alu_start, halted, halt_cause};
    exp = {2'(m_mode), e_en, e_start, (m_mode < 2), 2'(m_cause)};
    n_chk++;
    if (act !== exp || cycle_cnt !== m_cyc || instret_cnt !== m_ins) begin
      n_fail++;
      $display("FAIL model t=%0t {st,en,start,halted,cause} got %b want %b cyc got %0d want %0d ins got %0d want %0d",
               $time, act, exp, cycle_cnt, m_cyc, instret_cnt, m_ins);
    end
    if (rst) model_advance();
    @(posedge clk); #1;
    run_req = 0; halt_req = 0; step_req = 0;
  endtask

  // pc follows committed instructions through a 5-instruction loop 0..0x10
  task automatic auto_cycle();
    pc_value = tb_pc;
    cycle();
    if (s_en) tb_pc = (tb_pc == 32'h10) ? 32'h0 : tb_pc + 32'h4;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic run_until_halt(input int budget, output int cyc_used);
    cyc_used = 0;
    do begin auto_cycle(); cyc_used++; end while (!halted && cyc_used < budget);
    check("halt_within_budget", {31'b0, halted}, 32'd1);
  endtask

  typedef struct {
    logic run, hlt, multi, done;
    logic [31:0] pc;
    logic en, start;
    logic [1:0] st;
    logic [31:0] ins, cyc;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int hold_seen, used, waits, ins0, cnt_en;
    model_reset();
    // run / halt sequence, then a multi-cycle op finishing on its 5th ALU_WAIT
    tbl[0]  = '{1,0,0,0,32'h0, 0,0,2'd1,0,0};
    tbl[1]  = '{0,0,0,0,32'h0, 1,0,2'd2,0,0};
    tbl[2]  = '{0,0,0,0,32'h4, 1,0,2'd2,1,1};
    tbl[3]  = '{0,1,0,0,32'h8, 1,0,2'd2,2,2};
    tbl[4]  = '{0,0,0,0,32'hC, 0,0,2'd1,3,3};
    tbl[5]  = '{1,0,0,0,32'hC, 0,0,2'd1,3,3};
    tbl[6]  = '{0,0,1,0,32'hC, 0,1,2'd2,3,3};
    tbl[7]  = '{0,0,0,0,32'hC, 0,0,2'd3,3,4};
    tbl[8]  = '{0,0,0,0,32'hC, 0,0,2'd3,3,5};
    tbl[9]  = '{0,0,0,0,32'hC, 0,0,2'd3,3,6};
    tbl[10] = '{0,0,0,0,32'hC, 0,0,2'd3,3,7};
    tbl[11] = '{0,0,0,1,32'hC, 1,0,2'd3,3,8};
    tbl[12] = '{0,1,0,0,32'h10,1,0,2'd2,4,9};
    tbl[13] = '{0,0,0,0,32'h14,0,0,2'd1,5,10};

    // 1: reset and hold
    cycle(); cycle();
    check("reset_cpu_en", {31'b0, cpu_en}, 32'd0);
    check("reset_halted", {31'b0, halted}, 32'd1);
    rst = 1;
    hold_seen = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (s_state == 2'd0) hold_seen++; end
    check("hold_cycles", hold_seen, RESET_HOLD);
    check("after_hold_state", {30'b0, state}, 32'd1);

    // 2 + 4 (good op): table
    for (int i = 0; i < 14; i++) begin
      run_req = tbl[i].run; halt_req = tbl[i].hlt; multi_op = tbl[i].multi;
      alu_done = tbl[i].done; pc_value = tbl[i].pc;
      cycle();
      check($sformatf("tbl%0d_en", i), {31'b0, s_en}, {31'b0, tbl[i].en});
      check($sformatf("tbl%0d_start", i), {31'b0, s_start}, {31'b0, tbl[i].start});
      check($sformatf("tbl%0d_state", i), {30'b0, s_state}, {30'b0, tbl[i].st});
      check($sformatf("tbl%0d_ins", i), s_ins, tbl[i].ins);
      check($sformatf("tbl%0d_cyc", i), s_cyc, tbl[i].cyc);
    end
    multi_op = 0; alu_done = 0;
    check("tbl_cause", {30'b0, halt_cause}, 32'd0);

    // 3: breakpoint at 0xC, loop 0..0x10
    bp_en = 1; bp_addr = 32'hC; tb_pc = 0; ins0 = instret_cnt;
    run_req = 1; run_until_halt(20, used);
    check("bp1_cause", {30'b0, halt_cause}, 32'd1);
    check("bp1_ins", instret_cnt - ins0, 32'd3);
    check("bp1_pc", tb_pc, 32'hC);
    run_req = 1; run_until_halt(20, used);
    check("bp2_cause", {30'b0, halt_cause}, 32'd1);
    check("bp2_ins", instret_cnt - ins0, 32'd8);
    bp_en = 0;

    // 4b: ALU error
    ins0 = instret_cnt; run_req = 1; auto_cycle();
    multi_op = 1; auto_cycle(); multi_op = 0;
    auto_cycle(); auto_cycle();
    alu_done = 1; alu_error = 1; auto_cycle(); alu_done = 0; alu_error = 0;
    check("err_en", {31'b0, s_en}, 32'd0);
    check("err_cause", {30'b0, halt_cause}, 32'd2);
    check("err_ins", instret_cnt, ins0);

    // 5: watchdog
    ins0 = instret_cnt; run_req = 1; auto_cycle();
    multi_op = 1; waits = 0; used = 0;
    do begin auto_cycle(); used++; if (s_state == 2'd3) waits++; end while (!halted && used < 40);
    multi_op = 0;
    check("wd_halted", {31'b0, halted}, 32'd1);
    check("wd_waits", waits, WDOG_LIMIT);
    check("wd_cause", {30'b0, halt_cause}, 32'd3);
    check("wd_ins", instret_cnt, ins0);

    // 6: single step, then reset during ALU_WAIT
    ins0 = instret_cnt; cnt_en = 0; step_req = 1; auto_cycle();
    for (int i = 0; i < 4; i++) begin auto_cycle(); if (s_en) cnt_en++; end
    check("step_commits", cnt_en, 32'd1);
    check("step_ins", instret_cnt - ins0, 32'd1);
    check("step_cause", {30'b0, halt_cause}, 32'd0);
    check("step_halted", {31'b0, halted}, 32'd1);
    run_req = 1; auto_cycle();
    multi_op = 1; auto_cycle(); auto_cycle();
    check("pre_rst_state", {30'b0, state}, 32'd3);
    rst = 0; #1;
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_cyc", cycle_cnt, 32'd0);
    check("rst_ins", instret_cnt, 32'd0);
    check("rst_en", {31'b0, cpu_en}, 32'd0);
    multi_op = 0;
    cycle(); rst = 1;

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      run_req  = ($urandom_range(7) == 0);
      halt_req = ($urandom_range(15) == 0);
      step_req = ($urandom_range(7) == 0);
      bp_en    = ($urandom_range(1) == 0);
      bp_addr  = 32'($urandom_range(5)) << 2;
      multi_op = ($urandom_range(3) == 0);
      alu_done = ($urandom_range(4) == 0);
      alu_error = alu_done && ($urandom_range(3) == 0);
      if ($urandom_range(499) == 0) rst = 0;
      auto_cycle();
      rst = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
